multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that steps the 8-bit datapath: FETCH, DECODE, EXECUTE, MEM, WB.

---
 rtl/multicycle_sequencer.sv | 104 ++++++++++
 tb/tb_multicycle_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXECUTE/MEM/WB control FSM with PC; SEQ_MEM_TIMEOUT_EN adds memory-ack timeout
module multicycle_sequencer #(
   parameter int PC_WIDTH = 8
`ifdef SEQ_MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic [3:0]          op,
   input  logic                alu_zero,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                imem_ack,
   input  logic                dmem_ack,
   output logic                imem_req,
   output logic                ir_load,
   output logic                alu_en,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                reg_wr_en,
   output logic                link_sel,
   output logic [PC_WIDTH-1:0] pc,
   output logic                busy,
   output logic                retire,
   output logic                error,
   output logic [2:0]          state
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3, MEM = 3'd4, WB = 3'd5, ERROR = 3'd6
   } state_t;
   state_t st, nxt;
   logic [PC_WIDTH-1:0] pc_next;
   logic tmo;
   wire [PC_WIDTH-1:0] pc_inc = pc + PC_WIDTH'(1);
   wire is_sw = op == 4'b1011;
   wire is_jal = op == 4'b1001;
   assign state     = st;
   assign busy      = st != IDLE;
   assign imem_req  = st == FETCH;
   assign ir_load   = imem_req & imem_ack;
   assign alu_en    = st == EXECUTE;
   assign dmem_req  = st == MEM;
   assign dmem_we   = dmem_req & is_sw;
   assign reg_wr_en = st == WB;
   assign link_sel  = reg_wr_en & is_jal;
`ifdef SEQ_MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   assign tmo   = cnt == CW'(TIMEOUT_CYCLES - 1);
   assign error = st == ERROR;
   // wait counter restarts on every state change, so it measures cycles spent waiting for an ack
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (nxt != st) ? '0 : cnt + CW'(1);
`else
   assign tmo   = 1'b0;
   assign error = 1'b0;
`endif
   // next state, retire pulse and next PC; every retiring path then chooses IDLE or FETCH from stop
   always_comb begin
      nxt = st;
      pc_next = pc;
      retire = 1'b0;
      case (st)
         IDLE:    nxt = start ? FETCH : IDLE;
         FETCH:   nxt = imem_ack ? DECODE : tmo ? ERROR : FETCH;
         DECODE:  nxt = EXECUTE;
         EXECUTE:
            case (op)
               4'b1010, 4'b1011: nxt = MEM;
               4'b1000: begin retire = 1'b1; pc_next = branch_target; end
               4'b1100: begin retire = 1'b1; pc_next = alu_zero ? branch_target : pc_inc; end
               4'b1101: begin retire = 1'b1; pc_next = !alu_zero ? branch_target : pc_inc; end
               4'b0110, 4'b0111: begin retire = 1'b1; pc_next = pc_inc; end
               default: nxt = WB;
            endcase
         MEM: begin
            retire = dmem_ack & is_sw;
            pc_next = retire ? pc_inc : pc;
            nxt = (dmem_ack & !is_sw) ? WB : (!dmem_ack & tmo) ? ERROR : MEM;
         end
         WB: begin
            retire = 1'b1;
            pc_next = is_jal ? branch_target : pc_inc;
         end
`ifdef SEQ_MEM_TIMEOUT_EN
         ERROR:   nxt = start ? FETCH : ERROR;
`endif
         default: nxt = IDLE;
      endcase
      if (retire) nxt = stop ? IDLE : FETCH;
   end
   // state and program counter registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= IDLE;
         pc <= '0;
      end else begin
         st <= nxt;
         pc <= pc_next;
      end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed checks of the multicycle sequencer FSM, PC and handshakes
module tb_multicycle_sequencer;
   logic clk = 1'b0, reset, start, stop, alu_zero, imem_ack, dmem_ack;
   logic [3:0] op;
   logic [7:0] target, pc;
   logic imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_wr_en, link_sel, busy, retire, error;
   logic [2:0] state;
   int compared = 0, mismatched = 0;

   multicycle_sequencer #(
      .PC_WIDTH(8)
`ifdef SEQ_MEM_TIMEOUT_EN
      , .TIMEOUT_CYCLES(4)
`endif
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .op(op), .alu_zero(alu_zero),
      .branch_target(target), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
      .ir_load(ir_load), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .reg_wr_en(reg_wr_en), .link_sel(link_sel), .pc(pc), .busy(busy), .retire(retire),
      .error(error), .state(state)
   );

   always #5 clk = ~clk;

   wire [9:0] outs = {imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_wr_en, link_sel, busy, retire, error};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   initial begin
      reset = 1; start = 0; stop = 0; op = 0; alu_zero = 0; target = 0; imem_ack = 0; dmem_ack = 0;
      repeat (2) cyc;
      reset = 0;
      // test 1: reset while waiting in FETCH
      cyc; start = 1; #1 check("idle_state", state, 0);
      cyc; start = 0; #1 check("fetch_state", state, 1); check("fetch_imem_req", imem_req, 1); check("fetch_noack_irload", ir_load, 0);
      cyc; #1 check("fetch_wait_state", state, 1); check("fetch_wait_req", imem_req, 1);
      reset = 1; #1 check("rst_state", state, 0); check("rst_pc", pc, 0); check("rst_outs", outs, 0);
      cyc; #1 check("rst_hold_state", state, 0); check("rst_hold_outs", outs, 0);
      reset = 0;
      // test 2: ALU op with same-cycle acks
      cyc; start = 1; op = 4'b0001; imem_ack = 1; dmem_ack = 1; #1 check("t2_idle", state, 0);
      cyc; start = 0; #1 check("t2_fetch", state, 1); check("t2_irload", ir_load, 1);
      cyc; #1 check("t2_decode", state, 2);
      cyc; #1 check("t2_exec", state, 3); check("t2_alu_en", alu_en, 1); check("t2_exec_retire", retire, 0);
      cyc; #1 check("t2_wb", state, 5); check("t2_wb_flags", {reg_wr_en, retire, link_sel}, 3'b110); check("t2_wb_pc", pc, 0);
      // test 3: lw with dmem_ack three cycles late
      cyc; op = 4'b1010; dmem_ack = 0; #1 check("t2_pc", pc, 1); check("t3_fetch", state, 1);
      cyc; #1 check("t3_decode", state, 2);
      cyc; #1 check("t3_exec", state, 3);
      cyc; #1 check("t3_mem0", {state, dmem_req, dmem_we}, {3'd4, 2'b10});
      cyc; #1 check("t3_mem1", {state, dmem_req, retire}, {3'd4, 2'b10});
      cyc; #1 check("t3_mem2", {state, dmem_req}, {3'd4, 1'b1});
      cyc; dmem_ack = 1; #1 check("t3_mem3", {state, dmem_req, dmem_we, retire}, {3'd4, 3'b100});
      cyc; #1 check("t3_wb", {state, reg_wr_en, retire}, {3'd5, 2'b11}); check("t3_wb_pc", pc, 1);
      // test 4: beq / bne in both directions
      cyc; op = 4'b1100; alu_zero = 1; target = 8'h40; #1 check("t3_pc", pc, 2);
      cyc; cyc; #1 check("t4_beq_t_retire", {state, retire}, {3'd3, 1'b1}); check("t4_beq_t_nowr", reg_wr_en, 0);
      cyc; alu_zero = 0; #1 check("t4_beq_t_pc", pc, 8'h40); check("t4_beq_t_fetch", state, 1);
      cyc; cyc; #1 check("t4_beq_n_retire", retire, 1);
      cyc; op = 4'b1101; alu_zero = 1; #1 check("t4_beq_n_pc", pc, 8'h41);
      cyc; cyc;
      cyc; alu_zero = 0; target = 8'h10; #1 check("t4_bne_n_pc", pc, 8'h42);
      cyc; cyc;
      // jal: link in WB, pc = target
      cyc; op = 4'b1001; target = 8'hFF; #1 check("t4_bne_t_pc", pc, 8'h10);
      cyc; cyc; #1 check("jal_exec_retire", retire, 0);
      cyc; #1 check("jal_wb", {state, reg_wr_en, link_sel, retire}, {3'd5, 3'b111}); check("jal_wb_pc", pc, 8'h10);
      // test 5: shift at pc=FF wraps, stop at retire returns to IDLE
      cyc; op = 4'b0110; #1 check("jal_pc", pc, 8'hFF);
      cyc; cyc; stop = 1; #1 check("t5_exec", {state, retire, reg_wr_en}, {3'd3, 2'b10});
      cyc; #1 check("t5_idle", {state, busy}, {3'd0, 1'b0}); check("t5_pc_wrap", pc, 0); check("t5_outs", outs, 0);
      // sw with start and stop together: start wins, stop sampled at retire
      start = 1; op = 4'b1011;
      cyc; start = 0; #1 check("sw_fetch", state, 1);
      cyc; cyc; cyc; #1 check("sw_mem", {state, dmem_req, dmem_we, retire, reg_wr_en}, {3'd4, 4'b1110});
      cyc; #1 check("sw_idle", state, 0); check("sw_pc", pc, 1);
      stop = 0; imem_ack = 0; start = 1;
      cyc; start = 0; #1 check("t6_fetch0", state, 1);
      cyc; cyc; cyc; #1 check("t6_fetch3", {state, imem_req, error}, {3'd1, 2'b10});
`ifdef SEQ_MEM_TIMEOUT_EN
      // test 6: timeout after four unacknowledged FETCH cycles
      cyc; #1 check("t6_error", {state, error, busy, imem_req}, {3'd6, 3'b110});
      cyc; #1 check("t6_error_hold", {state, error}, {3'd6, 1'b1});
      start = 1;
      cyc; start = 0; #1 check("t6_recover", {state, error}, {3'd1, 1'b0}); check("t6_pc", pc, 1);
`else
      cyc; #1 check("t6_no_timeout", {state, error, imem_req}, {3'd1, 2'b01});
      cyc; #1 check("t6_still_wait", {state, error}, {3'd1, 1'b0});
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
